// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - handshake, ALU and debug bundle of the R-type issue controller
//
// Purpose: groups every non-clock/reset signal of alu_issue_ctrl.
//   slave  : controller view (accepts instructions, drives the ALU operands)
//   master : environment view (fetch side, ALU result, debug port)
// Signals:
//   in_valid/in_instr/in_ready          instruction word handshake
//   alu_rs_data/alu_rt_data/alu_funct/alu_shamt  registered ALU operands
//   alu_result                          combinational ALU result
//   done/err                            writeback / reject pulses
//   instr_cnt                           completed-instruction counter
//   dbg_addr/dbg_data                   register-file debug read
interface alu_issue_ctrl_if;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic [31:0] alu_rs_data;
  logic [31:0] alu_rt_data;
  logic [5:0]  alu_funct;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        done;
  logic        err;
  logic [15:0] instr_cnt;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  modport slave (
    input  in_valid, in_instr, alu_result, dbg_addr,
    output in_ready, alu_rs_data, alu_rt_data, alu_funct, alu_shamt,
           done, err, instr_cnt, dbg_data
  );

  modport master (
    output in_valid, in_instr, alu_result, dbg_addr,
    input  in_ready, alu_rs_data, alu_rt_data, alu_funct, alu_shamt,
           done, err, instr_cnt, dbg_data
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - multi-cycle MIPS R-type issue controller driving an external ALU
//
// Purpose: accepts R-type words, reads rs/rt from an internal 32x32 register
// file, presents operands/funct/shamt to a combinational ALU and writes the
// result back to rd. Sequence: IDLE -> READ -> EXEC -> WB (-> IDLE).
// Illegal opcode/funct is rejected from READ with a one-cycle err pulse.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (clears FSM, outputs, register file)
//   bus  alu_issue_ctrl_if.slave (handshake, ALU operands/result, done/err,
//        instr_cnt, debug register read)
// Configuration macro: ALU_ISSUE_OVERLAP_EN
//   defined   : in_ready also high in WB, a new word may be latched on the
//               writeback edge (one instruction per 3 cycles)
//   undefined : in_ready high only in IDLE (one instruction per 4 cycles)
module alu_issue_ctrl (
  input  logic            clk,
  input  logic            rst,
  alu_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] rs_data_q, rs_data_d;
  logic [31:0] rt_data_q, rt_data_d;
  logic [5:0]  funct_q, funct_d;
  logic [4:0]  shamt_q, shamt_d;
  logic [31:0] wb_q, wb_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];

  logic        in_ready;
  logic        done;
  logic        accept;
  logic        legal;

  logic [5:0]  dec_op;
  logic [4:0]  dec_rs;
  logic [4:0]  dec_rt;
  logic [4:0]  dec_rd;
  logic [4:0]  dec_shamt;
  logic [5:0]  dec_funct;

  assign dec_op    = instr_q[31:26];
  assign dec_rs    = instr_q[25:21];
  assign dec_rt    = instr_q[20:16];
  assign dec_rd    = instr_q[15:11];
  assign dec_shamt = instr_q[10:6];
  assign dec_funct = instr_q[5:0];

  always_comb begin
    legal = 1'b0;
    if (dec_op == OP_RTYPE) begin
      case (dec_funct)
        FN_SLL, FN_SLLV, FN_ADDU, FN_SUBU: legal = 1'b1;
        default:                           legal = 1'b0;
      endcase
    end
  end

  assign accept = bus.in_valid && in_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; in the default build accept is never high in WB,
  // so the WB arm falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_READ;
      S_READ:  state_d = legal ? S_EXEC : S_IDLE;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = accept ? S_READ : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (state_q == S_IDLE);
`ifdef ALU_ISSUE_OVERLAP_EN
    if (state_q == S_WB) in_ready = 1'b1;
`endif
    done = (state_q == S_WB);
  end

  // Datapath next values
  always_comb begin
    instr_d   = instr_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    funct_d   = funct_q;
    shamt_d   = shamt_q;
    wb_d      = wb_q;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    rf_d      = rf_q;

    if (accept) begin
      instr_d = bus.in_instr;
    end

    // Rejected words leave the ALU operands untouched.
    if (state_q == S_READ) begin
      if (legal) begin
        rs_data_d = rf_q[dec_rs];
        rt_data_d = rf_q[dec_rt];
        funct_d   = dec_funct;
        shamt_d   = dec_shamt;
      end else begin
        err_d = 1'b1;
      end
    end

    if (state_q == S_EXEC) begin
      wb_d = bus.alu_result;
    end

    // With overlap enabled instr_q still holds the retiring word here, the
    // new word only lands in instr_q on this same edge, so the next READ
    // sees the updated register file.
    if (state_q == S_WB) begin
      cnt_d = cnt_q + 16'd1;
      if (dec_rd != 5'd0) begin
        rf_d[dec_rd] = wb_q;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q   <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      funct_q   <= '0;
      shamt_q   <= '0;
      wb_q      <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      instr_q   <= instr_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      funct_q   <= funct_d;
      shamt_q   <= shamt_d;
      wb_q      <= wb_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.alu_rs_data = rs_data_q;
  assign bus.alu_rt_data = rt_data_q;
  assign bus.alu_funct   = funct_q;
  assign bus.alu_shamt   = shamt_q;
  assign bus.done        = done;
  assign bus.err         = err_q;
  assign bus.instr_cnt   = cnt_q;
  assign bus.dbg_data    = (bus.dbg_addr == 5'd0) ? 32'd0 : rf_q[bus.dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl with a behavioural ALU and register model
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_ctrl_if bus_if ();

  alu_issue_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int checks   = 0;
  int failures = 0;

  // Architectural model: register contents and completed count.
  logic [31:0] model_rf [32];
  int          model_cnt;
  logic [31:0] bias;
  logic [5:0]  last_fn;
  logic [4:0]  last_sh;
  logic [31:0] last_a;
  logic [31:0] last_b;

  // Stand-in ALU; bias lets ADDU synthesise constants from $0 during preload.
  function automatic logic [31:0] ref_alu(input logic [5:0] fn, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh,
                                          input logic [31:0] k);
    case (fn)
      6'h21:   return a + b + k;
      6'h23:   return a - b;
      6'h00:   return b << sh;
      6'h04:   return b << a[4:0];
      default: return 32'd0;
    endcase
  endfunction

  always_comb begin
    bus_if.alu_result = ref_alu(bus_if.alu_funct, bus_if.alu_rs_data, bus_if.alu_rt_data,
                                bus_if.alu_shamt, bias);
  end

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic dbg_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    bus_if.dbg_addr = addr;
    #1;
    check(tag, bus_if.dbg_data, exp);
  endtask

  // Called at a negedge; returns at the negedge of cycle N+1 (READ).
  task automatic handshake(input logic [31:0] ins);
    int t;
    t = 0;
    while (bus_if.in_ready !== 1'b1 && t < 16) begin
      @(negedge clk);
      t++;
    end
    if (t >= 16) check("ready_timeout", bus_if.in_ready, 32'd1);
    bus_if.in_valid = 1'b1;
    bus_if.in_instr = ins;
    @(posedge clk);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    bus_if.in_instr = $urandom;
  endtask

  task automatic run_instr(input logic [31:0] ins);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    logic        ok;
    logic [31:0] a, b, r;
    logic        wb_ready;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
    rd = ins[15:11]; sh = ins[10:6];  fn = ins[5:0];
    ok = (op == 6'h00) && (fn == 6'h00 || fn == 6'h04 || fn == 6'h21 || fn == 6'h23);
    a = model_rf[rs];
    b = model_rf[rt];
    r = ref_alu(fn, a, b, sh, bias);
`ifdef ALU_ISSUE_OVERLAP_EN
    wb_ready = 1'b1;
`else
    wb_ready = 1'b0;
`endif
    handshake(ins);
    check("read_ready", bus_if.in_ready, 32'd0);
    check("read_done", bus_if.done, 32'd0);
    check("read_err", bus_if.err, 32'd0);
    @(negedge clk);
    if (ok) begin
      check("exec_funct", bus_if.alu_funct, fn);
      check("exec_shamt", bus_if.alu_shamt, sh);
      check("exec_rs", bus_if.alu_rs_data, a);
      check("exec_rt", bus_if.alu_rt_data, b);
      check("exec_done", bus_if.done, 32'd0);
      check("exec_ready", bus_if.in_ready, 32'd0);
      @(negedge clk);
      check("wb_done", bus_if.done, 32'd1);
      check("wb_err", bus_if.err, 32'd0);
      check("wb_ready", bus_if.in_ready, wb_ready);
      check("wb_cnt", bus_if.instr_cnt, model_cnt[15:0]);
      if (rd != 5'd0) model_rf[rd] = r;
      model_cnt++;
      last_fn = fn; last_sh = sh; last_a = a; last_b = b;
      @(negedge clk);
      check("post_done", bus_if.done, 32'd0);
      check("post_cnt", bus_if.instr_cnt, model_cnt[15:0]);
      dbg_check("post_rd", rd, model_rf[rd]);
    end else begin
      check("rej_err", bus_if.err, 32'd1);
      check("rej_done", bus_if.done, 32'd0);
      check("rej_ready", bus_if.in_ready, 32'd1);
      check("rej_funct", bus_if.alu_funct, last_fn);
      check("rej_rs", bus_if.alu_rs_data, last_a);
      @(negedge clk);
      check("rej_err_clr", bus_if.err, 32'd0);
      check("rej_nodone", bus_if.done, 32'd0);
      check("rej_cnt", bus_if.instr_cnt, model_cnt[15:0]);
      dbg_check("rej_rd", rd, model_rf[rd]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    model_cnt = 0;
    last_fn = '0; last_sh = '0; last_a = '0; last_b = '0;
  endtask

  initial begin
    logic [5:0] fn_tab [6];
    logic [31:0] ins;
    logic [5:0] op;
    int hs [2];
    int k, cyc;
    fn_tab[0] = 6'h00; fn_tab[1] = 6'h04; fn_tab[2] = 6'h21;
    fn_tab[3] = 6'h23; fn_tab[4] = 6'h20; fn_tab[5] = 6'h2A;

    model_reset();
    bias            = 32'd0;
    rst             = 1'b1;
    bus_if.in_valid = 1'b0;
    bus_if.in_instr = 32'd0;
    bus_if.dbg_addr = 5'd0;
    repeat (3) @(negedge clk);
    check("rst_ready", bus_if.in_ready, 32'd1);
    check("rst_done", bus_if.done, 32'd0);
    check("rst_err", bus_if.err, 32'd0);
    check("rst_cnt", bus_if.instr_cnt, 32'd0);
    check("rst_rs", bus_if.alu_rs_data, 32'd0);
    check("rst_rt", bus_if.alu_rt_data, 32'd0);
    check("rst_funct", bus_if.alu_funct, 32'd0);
    check("rst_shamt", bus_if.alu_shamt, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) dbg_check("rst_rf", i[4:0], 32'd0);
    check("idle_ready", bus_if.in_ready, 32'd1);

    // Preload $1=10, $2=20 via ADDU from $0 with the bench ALU bias.
    bias = 32'd10; run_instr(rtype(6'h00, 5'd0, 5'd0, 5'd1, 5'd0, 6'h21));
    bias = 32'd20; run_instr(rtype(6'h00, 5'd0, 5'd0, 5'd2, 5'd0, 6'h21));
    bias = 32'd0;

    run_instr(rtype(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21));
    dbg_check("addu_30", 5'd3, 32'd30);
    run_instr(rtype(6'h00, 5'd3, 5'd1, 5'd4, 5'd0, 6'h23));
    dbg_check("subu_20", 5'd4, 32'd20);
    run_instr(rtype(6'h00, 5'd1, 5'd3, 5'd5, 5'd0, 6'h23));
    dbg_check("subu_neg", 5'd5, 32'hFFFF_FFEC);
    run_instr(rtype(6'h00, 5'd0, 5'd1, 5'd6, 5'd2, 6'h00));
    dbg_check("sll_40", 5'd6, 32'd40);
    run_instr(rtype(6'h00, 5'd2, 5'd1, 5'd7, 5'd0, 6'h04));
    dbg_check("sllv", 5'd7, 32'h00A0_0000);

    // Rejected: unsupported funct, then bad opcode; then rd=0 writeback.
    run_instr(rtype(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
    dbg_check("rej_keep3", 5'd3, 32'd30);
    run_instr(rtype(6'h08, 5'd1, 5'd2, 5'd4, 5'd0, 6'h21));
    run_instr(rtype(6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h21));
    dbg_check("r0_zero", 5'd0, 32'd0);

    // Randomised preload of $8..$15, then random mixes over $0..$15.
    for (int i = 8; i < 16; i++) begin
      bias = $urandom;
      run_instr(rtype(6'h00, 5'd0, 5'd0, i[4:0], 5'd0, 6'h21));
    end
    bias = 32'd0;
    for (int n = 0; n < 40; n++) begin
      op  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'h00;
      ins = rtype(op, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                  5'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
                  fn_tab[$urandom_range(0, 5)]);
      run_instr(ins);
    end
    for (int i = 0; i < 16; i++) dbg_check("rand_rf", i[4:0], model_rf[i]);

`ifdef ALU_ISSUE_OVERLAP_EN
    // Back-to-back dependent ADDUs with in_valid held.
    k = 0; cyc = 0; hs[0] = 0; hs[1] = 0;
    bus_if.in_valid = 1'b1;
    bus_if.in_instr = rtype(6'h00, 5'd1, 5'd1, 5'd20, 5'd0, 6'h21);
    while (k < 2 && cyc < 20) begin
      if (bus_if.in_ready === 1'b1) begin
        hs[k] = cyc;
        k++;
      end
      @(negedge clk);
      cyc++;
      if (k == 1) bus_if.in_instr = rtype(6'h00, 5'd20, 5'd1, 5'd21, 5'd0, 6'h21);
      if (k == 2) bus_if.in_valid = 1'b0;
    end
    check("ovl_hs_count", k, 32'd2);
    check("ovl_spacing", hs[1] - hs[0], 32'd3);
    model_rf[20] = model_rf[1] + model_rf[1];
    model_rf[21] = model_rf[20] + model_rf[1];
    model_cnt += 2;
    repeat (3) @(negedge clk);
    dbg_check("ovl_first", 5'd20, model_rf[20]);
    dbg_check("ovl_dep", 5'd21, model_rf[21]);
    check("ovl_cnt", bus_if.instr_cnt, model_cnt[15:0]);
`endif

    // Reset during EXEC abandons the instruction and clears everything.
    handshake(rtype(6'h00, 5'd1, 5'd2, 5'd8, 5'd0, 6'h21));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mrst_ready", bus_if.in_ready, 32'd1);
    check("mrst_done", bus_if.done, 32'd0);
    check("mrst_funct", bus_if.alu_funct, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("mrst_nodone", bus_if.done, 32'd0);
      check("mrst_noerr", bus_if.err, 32'd0);
    end
    check("mrst_cnt", bus_if.instr_cnt, 32'd0);
    check("mrst_ready2", bus_if.in_ready, 32'd1);
    dbg_check("mrst_r8", 5'd8, 32'd0);
    dbg_check("mrst_r1", 5'd1, 32'd0);

    bias = 32'd5;
    run_instr(rtype(6'h00, 5'd0, 5'd0, 5'd9, 5'd0, 6'h21));
    bias = 32'd0;
    dbg_check("after_rst_r9", 5'd9, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
